// File: rtl/video_zone_dimmer_if.sv
// Video input bundle from the LVDS receiver into the zone dimmer.
// Stream without backpressure: de qualifies data_r/g/b on every clock, vs frames the stream.
interface video_zone_dimmer_if;
    logic       vs;
    logic       de;
    logic [7:0] data_r;
    logic [7:0] data_g;
    logic [7:0] data_b;

    modport master (output vs, de, data_r, data_g, data_b);
    modport slave  (input  vs, de, data_r, data_g, data_b);
endinterface

// File: rtl/video_zone_dimmer.sv
// Per-zone MiniLED backlight levels: peak of max(R,G,B) per zone, then a per-mode
// commit (IIR / raw / full / global) into the published zone vector once per frame.
module video_zone_dimmer #(
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int ZONES_X   = 24,
    parameter int ZONES_Y   = 15,
    parameter int DW        = 8,
    parameter int IIR_K     = 2,
    parameter int MIN_LEVEL = 0,
    parameter int VS_POL    = 1
) (
    input  logic                          I_pix_clk,
    input  logic                          I_rst_n,
    video_zone_dimmer_if.slave            vid,
    input  logic [1:0]                    I_mode,
    input  logic [DW-1:0]                 I_level,
    output logic [DW*ZONES_X*ZONES_Y-1:0] O_led_light,
    output logic                          O_frame_done,
    output logic                          O_frame_err,
    output logic                          O_busy,
    output logic [1:0]                    O_dbg_state
);
    localparam int NZ  = ZONES_X * ZONES_Y;
    localparam int ZW  = H_ACTIVE / ZONES_X;
    localparam int ZH  = V_ACTIVE / ZONES_Y;
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 2);
    localparam int SXW = $clog2(ZW + 1);
    localparam int SYW = $clog2(ZH + 1);
    localparam int ZXW = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;
    localparam int KI  = $clog2(NZ);

    localparam logic [XW-1:0]  H_MAX   = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  V_MAX   = YW'(V_ACTIVE);
    localparam logic [YW-1:0]  Y_SAT   = YW'(V_ACTIVE + 1);
    localparam logic [SXW-1:0] SX_LAST = SXW'(ZW - 1);
    localparam logic [SYW-1:0] SY_LAST = SYW'(ZH - 1);
    localparam logic [ZXW-1:0] ZX_LAST = ZXW'(ZONES_X - 1);
    localparam logic [KI-1:0]  K_LAST  = KI'(NZ - 1);
    localparam logic [KI-1:0]  ZX_K    = KI'(ZONES_X);
    localparam logic [DW-1:0]  MIN_V   = DW'(MIN_LEVEL);

    // The first band's first shadow write must land after the last commit read.
    if (H_ACTIVE % ZONES_X != 0) begin : g_chk_h
        $error("H_ACTIVE must be a multiple of ZONES_X");
    end
    if (V_ACTIVE % ZONES_Y != 0) begin : g_chk_v
        $error("V_ACTIVE must be a multiple of ZONES_Y");
    end
    if (ZH * H_ACTIVE <= NZ) begin : g_chk_commit
        $error("one band of pixels must outlast the commit sweep");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_COMMIT = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic            r_first, r_vs_act, r_de_d;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [SXW-1:0]  r_sub_x;
    logic [SYW-1:0]  r_sub_y;
    logic [ZXW-1:0]  r_zx;
    logic [KI-1:0]   r_zbase, r_k;
    logic [1:0]      r_mode;
    logic [DW-1:0]   r_level;
    logic            r_frame_done, r_frame_err;
    logic [DW-1:0]   r_acc    [ZONES_X];
    logic [DW-1:0]   r_shadow [NZ];
    logic [DW-1:0]   r_out    [NZ];

    logic            w_vs_act, w_vs_edge, w_de_fall, w_pix_ok, w_zone_done;
    logic            w_start_commit, w_err, w_commit_last;
    logic [7:0]      w_max8;
    logic [DW-1:0]   w_pix, w_pix_max, w_commit_val;
    logic [KI-1:0]   w_zidx;

    assign w_vs_act      = (vid.vs == VS_POL[0]);
    assign w_vs_edge     = w_vs_act & ~r_vs_act;
    assign w_de_fall     = r_de_d & ~vid.de;
    assign w_pix_ok      = vid.de && (r_x < H_MAX) && (r_y < V_MAX);
    assign w_zone_done   = w_pix_ok && (r_sub_x == SX_LAST) && (r_sub_y == SY_LAST);
    assign w_commit_last = (r_k == K_LAST);
    assign w_zidx        = r_zbase + KI'(r_zx);

    always_comb begin
        w_max8 = vid.data_r;
        if (vid.data_g > w_max8) w_max8 = vid.data_g;
        if (vid.data_b > w_max8) w_max8 = vid.data_b;
    end

    if (DW == 8) begin : g_pix_eq
        assign w_pix = w_max8;
    end else if (DW > 8) begin : g_pix_pad
        assign w_pix = {w_max8, {(DW-8){1'b0}}};
    end else begin : g_pix_trunc
        assign w_pix = w_max8[7 -: DW];
    end

    assign w_pix_max = (w_pix > r_acc[r_zx]) ? w_pix : r_acc[r_zx];

    always_comb begin
        w_state_nxt    = r_state;
        w_start_commit = 1'b0;
        w_err          = 1'b0;
        case (r_state)
            S_IDLE:   if (w_vs_edge || (vid.de && r_first)) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_vs_edge) begin
                          if (r_y == V_MAX) begin
                              w_state_nxt    = S_COMMIT;
                              w_start_commit = 1'b1;
                          end else begin
                              w_state_nxt = S_IDLE;
                              w_err       = 1'b1;
                          end
                      end
            S_COMMIT: if (w_commit_last) w_state_nxt = S_ACTIVE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            r_state <= S_IDLE;
            r_first <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_IDLE) r_first <= 1'b0;
        end
    end

    // IIR step magnitude is truncated toward zero so decay mirrors rise; a nonzero error always moves by at least 1.
    logic signed [DW:0] w_d;
    logic [DW:0]        w_mag, w_step, w_sum;
    logic [DW-1:0]      w_sh, w_cur, w_iir;
    always_comb begin
        w_sh   = r_shadow[r_k];
        w_cur  = r_out[r_k];
        w_d    = $signed({1'b0, w_sh}) - $signed({1'b0, w_cur});
        w_mag  = w_d[DW] ? $unsigned(-w_d) : $unsigned(w_d);
        w_step = w_mag >> IIR_K;
        if ((w_step == '0) && (w_d != '0)) w_step = (DW+1)'(1);
        w_sum  = w_d[DW] ? ({1'b0, w_cur} - w_step) : ({1'b0, w_cur} + w_step);
        w_iir  = (w_sum[DW-1:0] > MIN_V) ? w_sum[DW-1:0] : MIN_V;
        case (r_mode)
            2'b00:   w_commit_val = w_iir;
            2'b01:   w_commit_val = (w_sh > MIN_V) ? w_sh : MIN_V;
            2'b10:   w_commit_val = '1;
            default: w_commit_val = r_level;
        endcase
    end

    always_ff @(posedge I_pix_clk) begin
        if (!I_rst_n) begin
            r_vs_act <= 1'b0;  r_de_d  <= 1'b0;
            r_x      <= '0;    r_y     <= '0;
            r_sub_x  <= '0;    r_sub_y <= '0;
            r_zx     <= '0;    r_zbase <= '0;
            r_k      <= '0;    r_mode  <= '0;    r_level <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            for (int i = 0; i < ZONES_X; i++) r_acc[i] <= '0;
            for (int i = 0; i < NZ; i++) begin
                r_shadow[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            r_vs_act     <= w_vs_act;
            r_de_d       <= vid.de;
            r_frame_done <= 1'b0;
            r_frame_err  <= w_err;

            if (w_vs_edge) begin
                r_x <= '0;  r_y <= '0;  r_sub_x <= '0;  r_sub_y <= '0;
                r_zx <= '0; r_zbase <= '0;
            end else if (w_de_fall) begin
                r_x <= '0;  r_sub_x <= '0;  r_zx <= '0;
                if (r_y != Y_SAT) r_y <= r_y + 1'b1;
                if (r_y < V_MAX) begin
                    if (r_sub_y == SY_LAST) begin
                        r_sub_y <= '0;
                        r_zbase <= r_zbase + ZX_K;
                    end else begin
                        r_sub_y <= r_sub_y + 1'b1;
                    end
                end
            end else if (vid.de && (r_x < H_MAX)) begin
                r_x <= r_x + 1'b1;
                if (w_pix_ok) begin
                    if (r_sub_x == SX_LAST) begin
                        r_sub_x <= '0;
                        if (r_zx != ZX_LAST) r_zx <= r_zx + 1'b1;
                    end else begin
                        r_sub_x <= r_sub_x + 1'b1;
                    end
                end
            end

            if (w_vs_edge) begin
                for (int i = 0; i < ZONES_X; i++) r_acc[i] <= '0;
            end else if (w_zone_done) begin
                r_shadow[w_zidx] <= w_pix_max;
                r_acc[r_zx]      <= '0;
            end else if (w_pix_ok) begin
                r_acc[r_zx] <= w_pix_max;
            end

            if (w_start_commit) begin
                r_k     <= '0;
                r_mode  <= I_mode;
                r_level <= I_level;
            end else if (r_state == S_COMMIT) begin
                r_out[r_k] <= w_commit_val;
                if (w_commit_last) r_frame_done <= 1'b1;
                else               r_k <= r_k + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NZ; g++) begin : g_flat
        assign O_led_light[g*DW +: DW] = r_out[g];
    end

    assign O_frame_done = r_frame_done;
    assign O_frame_err  = r_frame_err;
    assign O_busy       = (r_state == S_COMMIT);
    assign O_dbg_state  = r_state;
endmodule
